// File: rtl/sram_audio_sequencer_if.sv
// SRAM pin bundle between the audio sequencer (master) and the SRAM / DQ tristate pad logic (slave).
interface sram_audio_sequencer_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] oSRAM_ADDR;
    logic [DATA_W-1:0] oSRAM_WDATA;
    logic [DATA_W-1:0] iSRAM_RDATA;
    logic              oSRAM_WE_N;
    logic              oSRAM_OE_N;
    logic              oSRAM_DQ_OE;

    modport master (
        output oSRAM_ADDR, oSRAM_WDATA, oSRAM_WE_N, oSRAM_OE_N, oSRAM_DQ_OE,
        input  iSRAM_RDATA
    );

    modport slave (
        input  oSRAM_ADDR, oSRAM_WDATA, oSRAM_WE_N, oSRAM_OE_N, oSRAM_DQ_OE,
        output iSRAM_RDATA
    );
endinterface

// File: rtl/sram_audio_sequencer.sv
// Shares one SRAM between stereo record and playback: one left/right access pair per LRCK frame.
// Define AUDSEQ_LOOP_EN to make playback wrap to address 0 instead of stopping at the recorded length.
module sram_audio_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iLRCK,
    input  logic                   iREC,
    input  logic                   iPLAY,
    input  logic [DATA_W-1:0]      iIN_L,
    input  logic [DATA_W-1:0]      iIN_R,
    output logic [DATA_W-1:0]      oOUT_L,
    output logic [DATA_W-1:0]      oOUT_R,
    sram_audio_sequencer_if.master sram,
    output logic [ADDR_W-1:0]      oREC_LEN,
    output logic                   oFULL,
    output logic                   oOVERRUN
);
    typedef enum logic [1:0] {IDLE, ACC_L, ACC_R} state_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_REC, MODE_PLAY} mode_t;

    localparam int                CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(WAIT_CYC / 2);
    localparam logic [ADDR_W-1:0] PTR_LAST = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(2);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_new, acc_mode;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_eff, ptr_cur, ptr_inc, len_eff, addr_d;
    logic [DATA_W-1:0] smp_l_q, smp_r_q, rd_l_q, wdata_d;
    logic              lrck_s1, lrck_s2, lrck_d, frame_req;
    logic              mode_chg, full_eff, done_q, done_eff, go, acc_last;
    logic              rec_acc, play_acc, we_n_d, oe_n_d, dq_oe_d;

    // Write strobe sits inside the access so address and data have setup and hold around it.
    function automatic logic we_slot(input logic [CNT_W-1:0] c);
        if (WAIT_CYC >= 3) return (c != '0) && (c != CNT_LAST);
        return c == CNT_MID;
    endfunction

    assign frame_req = lrck_s2 & ~lrck_d;
    assign acc_last  = (cnt_q == CNT_LAST);
    assign ptr_inc   = ptr_q + PTR_STEP;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each synchroniser stage takes the previous stage's pre-edge value.
            lrck_s1 <= iLRCK;
            lrck_s2 <= lrck_s1;
            lrck_d  <= lrck_s2;
        end
    end

    // Frame-start view of pointer and flags once a mode change has been applied.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
        mode_new = MODE_OFF;
        if (iREC)       mode_new = MODE_REC;
        else if (iPLAY) mode_new = MODE_PLAY;
        mode_chg = (mode_new != mode_q);
        ptr_eff  = mode_chg ? '0 : ptr_q;
        done_eff = mode_chg ? 1'b0 : done_q;
        full_eff = (mode_chg && mode_new == MODE_REC) ? 1'b0 : oFULL;
        len_eff  = (mode_chg && mode_new == MODE_REC) ? '0 : oREC_LEN;
        unique case (mode_new)
            MODE_REC:  go = !full_eff;
            MODE_PLAY: go = (full_eff || len_eff != '0) && !done_eff;
            default:   go = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (frame_req && go) begin
                state_d = ACC_L;
                cnt_d   = '0;
            end
            ACC_L: if (acc_last) begin
                state_d = ACC_R;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            ACC_R: if (acc_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase

        // SRAM pins are registered from the next state so they change only on iCLK edges.
        acc_mode = (state_q == IDLE) ? mode_new : mode_q;
        ptr_cur  = (state_q == IDLE) ? ptr_eff : ptr_q;
        rec_acc  = (state_d != IDLE) && (acc_mode == MODE_REC);
        play_acc = (state_d != IDLE) && (acc_mode == MODE_PLAY);
        addr_d   = sram.oSRAM_ADDR;
        wdata_d  = sram.oSRAM_WDATA;
        if (state_d == ACC_L) begin
            addr_d  = ptr_cur;
            wdata_d = (state_q == IDLE) ? iIN_L : smp_l_q;
        end else if (state_d == ACC_R) begin
            addr_d  = ptr_cur + ADDR_W'(1);
            wdata_d = smp_r_q;
        end
        we_n_d  = !(rec_acc && we_slot(cnt_d));
        oe_n_d  = !play_acc;
        dq_oe_d = rec_acc;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            sram.oSRAM_ADDR  <= '0;
            sram.oSRAM_WDATA <= '0;
            sram.oSRAM_WE_N  <= 1'b1;
            sram.oSRAM_OE_N  <= 1'b1;
            sram.oSRAM_DQ_OE <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            sram.oSRAM_ADDR  <= addr_d;
            sram.oSRAM_WDATA <= wdata_d;
            sram.oSRAM_WE_N  <= we_n_d;
            sram.oSRAM_OE_N  <= oe_n_d;
            sram.oSRAM_DQ_OE <= dq_oe_d;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode_q   <= MODE_OFF;
            ptr_q    <= '0;
            oREC_LEN <= '0;
            oFULL    <= 1'b0;
            done_q   <= 1'b0;
            oOVERRUN <= 1'b0;
            smp_l_q  <= '0;
            smp_r_q  <= '0;
            rd_l_q   <= '0;
            oOUT_L   <= '0;
            oOUT_R   <= '0;
        end else begin
            oOVERRUN <= frame_req && (state_q != IDLE);
            if (state_q == IDLE && frame_req) begin
                mode_q   <= mode_new;
                ptr_q    <= ptr_eff;
                oREC_LEN <= len_eff;
                oFULL    <= full_eff;
                done_q   <= done_eff;
                if (go && mode_new == MODE_REC) begin
                    smp_l_q <= iIN_L;
                    smp_r_q <= iIN_R;
                end
                if (!(go && mode_new == MODE_PLAY)) begin
                    oOUT_L <= '0;
                    oOUT_R <= '0;
                end
            end
            if (state_q == ACC_L && acc_last) rd_l_q <= sram.iSRAM_RDATA;
            if (state_q == ACC_R && acc_last) begin
                ptr_q <= ptr_inc;
                if (mode_q == MODE_REC) begin
                    oREC_LEN <= ptr_inc;
                    if (ptr_q == PTR_LAST) oFULL <= 1'b1;
                end else if (mode_q == MODE_PLAY) begin
                    oOUT_L <= rd_l_q;
                    oOUT_R <= sram.iSRAM_RDATA;
                    if (ptr_inc == oREC_LEN) begin
`ifdef AUDSEQ_LOOP_EN
                        ptr_q <= '0;
`else
                        done_q <= 1'b1;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_audio_sequencer.sv
// Scoreboard bench: stimulus queues expected SRAM writes and playback pairs, a monitor pops and compares.
module tb_sram_audio_sequencer;
    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;

    logic iCLK = 1'b0, iRST = 1'b1, iLRCK = 1'b0, iREC = 1'b0, iPLAY = 1'b0;
    logic [DW-1:0] iIN_L = '0, iIN_R = '0;
    logic [DW-1:0] out_l, out_r, out_l4, out_r4;
    logic [AW-1:0] rec_len, rec_len4;
    logic full, full4, ovr, ovr4;

    sram_audio_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();
    sram_audio_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) sif4 ();

    sram_audio_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2)) dut (
        .iCLK(iCLK), .iRST(iRST), .iLRCK(iLRCK), .iREC(iREC), .iPLAY(iPLAY),
        .iIN_L(iIN_L), .iIN_R(iIN_R), .oOUT_L(out_l), .oOUT_R(out_r), .sram(sif.master),
        .oREC_LEN(rec_len), .oFULL(full), .oOVERRUN(ovr)
    );

    sram_audio_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(4)) dut_w4 (
        .iCLK(iCLK), .iRST(iRST), .iLRCK(iLRCK), .iREC(iREC), .iPLAY(iPLAY),
        .iIN_L(iIN_L), .iIN_R(iIN_R), .oOUT_L(out_l4), .oOUT_R(out_r4), .sram(sif4.master),
        .oREC_LEN(rec_len4), .oFULL(full4), .oOVERRUN(ovr4)
    );

    always #5 iCLK = ~iCLK;

    logic [DW-1:0] mem [2**AW];
    assign sif.iSRAM_RDATA  = sif.oSRAM_OE_N ? 16'hDEAD : mem[sif.oSRAM_ADDR];
    assign sif4.iSRAM_RDATA = 16'h0000;

    wr_t   exp_wr[$];
    pair_t exp_out[$];
    wr_t   e_wr;
    pair_t e_out;
    int n_cmp = 0, n_bad = 0;
    int wr_windows = 0, rd_frames = 0, wr4_windows = 0, ovr_cnt = 0, ovr4_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each WE_N low window is one write, each OE_N release ends one playback frame.
    logic prev_we = 1'b1, prev_oe = 1'b1, prev_we4 = 1'b1, w_bus_ok = 1'b1;
    int low_len = 0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;

    always @(negedge iCLK) begin
        if (ovr)  ovr_cnt++;
        if (ovr4) ovr4_cnt++;
        if (!sif4.oSRAM_WE_N && prev_we4) wr4_windows++;
        prev_we4 = sif4.oSRAM_WE_N;

        if (!sif.oSRAM_WE_N) begin
            if (prev_we) begin
                low_len  = 0;
                w_addr   = sif.oSRAM_ADDR;
                w_data   = sif.oSRAM_WDATA;
                w_bus_ok = 1'b1;
            end
            low_len++;
            if (!sif.oSRAM_DQ_OE || !sif.oSRAM_OE_N || sif.oSRAM_ADDR != w_addr || sif.oSRAM_WDATA != w_data)
                w_bus_ok = 1'b0;
            mem[sif.oSRAM_ADDR] = sif.oSRAM_WDATA;
        end else if (!prev_we) begin
            wr_windows++;
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: got write addr %0h data %0h, expected no write", w_addr, w_data);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wr_addr", 32'(w_addr), 32'(e_wr.addr));
                check("wr_data", 32'(w_data), 32'(e_wr.data));
                check("we_low_cycles", 32'(low_len), 32'd1);
                check("wr_bus_stable", 32'(w_bus_ok), 32'd1);
            end
        end
        prev_we = sif.oSRAM_WE_N;

        if (sif.oSRAM_OE_N && !prev_oe) begin
            rd_frames++;
            if (exp_out.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got out %0h/%0h, expected no playback frame", out_l, out_r);
            end else begin
                e_out = exp_out.pop_front();
                check("out_l", 32'(out_l), 32'(e_out.l));
                check("out_r", 32'(out_r), 32'(e_out.r));
            end
        end
        prev_oe = sif.oSRAM_OE_N;
    end

    task automatic push_wr(input int a, input logic [DW-1:0] d);
        exp_wr.push_back(wr_t'{AW'(a), d});
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                         input bit sw_play, input bit double_edge);
        iIN_L = l;
        iIN_R = r;
        @(negedge iCLK) iLRCK = 1'b1;
        if (double_edge) begin
            @(negedge iCLK) iLRCK = 1'b0;
            repeat (2) @(negedge iCLK);
            iLRCK = 1'b1;
        end
        repeat (4) @(negedge iCLK);
        if (sw_play) begin
            iREC  = 1'b0;
            iPLAY = 1'b1;
        end
        repeat (4) @(negedge iCLK);
        iLRCK = 1'b0;
        repeat (10) @(negedge iCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, snap4, snap_o, snap_o4;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        check("rst_we_n",  32'(sif.oSRAM_WE_N),  32'd1);
        check("rst_oe_n",  32'(sif.oSRAM_OE_N),  32'd1);
        check("rst_dq_oe", 32'(sif.oSRAM_DQ_OE), 32'd0);
        check("rst_addr",  32'(sif.oSRAM_ADDR),  32'd0);
        check("rst_wdata", 32'(sif.oSRAM_WDATA), 32'd0);
        check("rst_out",   {out_l, out_r},       32'd0);
        check("rst_len",   32'(rec_len),         32'd0);
        check("rst_full",  32'(full),            32'd0);
        check("rst_ovr",   32'(ovr),             32'd0);

        // Record three frames, then play them back.
        iREC = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_wr(2*k,     16'(16'h1111 + k));
            push_wr(2*k + 1, 16'(16'h2222 + k));
            frame(16'(16'h1111 + k), 16'(16'h2222 + k), 1'b0, 1'b0);
        end
        check("rec_len_3f", 32'(rec_len), 32'd6);
        check("full_3f",    32'(full),    32'd0);

        iREC  = 1'b0;
        iPLAY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_out.push_back(pair_t'{16'(16'h1111 + k), 16'(16'h2222 + k)});
            frame('0, '0, 1'b0, 1'b0);
        end
        snap = rd_frames;
`ifdef AUDSEQ_LOOP_EN
        exp_out.push_back(pair_t'{16'h1111, 16'h2222});
        frame('0, '0, 1'b0, 1'b0);
        check("loop_frame_read", 32'(rd_frames), 32'(snap + 1));
`else
        frame('0, '0, 1'b0, 1'b0);
        check("end_no_access", 32'(rd_frames), 32'(snap));
        check("end_out_zero",  {out_l, out_r}, 32'd0);
`endif

        // REC -> PLAY switch in mid-frame: the write pair completes, the next frame reads from 0.
        iPLAY = 1'b0;
        iREC  = 1'b1;
        push_wr(0, 16'hAAAA);
        push_wr(1, 16'hBBBB);
        frame(16'hAAAA, 16'hBBBB, 1'b1, 1'b0);
        check("switch_rec_len", 32'(rec_len), 32'd2);
        exp_out.push_back(pair_t'{16'hAAAA, 16'hBBBB});
        frame('0, '0, 1'b0, 1'b0);

        // Second LRCK edge three cycles after the first: dropped with one overrun pulse.
        iPLAY = 1'b0;
        iREC  = 1'b1;
        snap = wr_windows; snap4 = wr4_windows; snap_o = ovr_cnt; snap_o4 = ovr4_cnt;
        push_wr(0, 16'h5555);
        push_wr(1, 16'h6666);
        frame(16'h5555, 16'h6666, 1'b0, 1'b1);
        check("ovr_pulses",    32'(ovr_cnt - snap_o),       32'd1);
        check("ovr4_pulses",   32'(ovr4_cnt - snap_o4),     32'd1);
        check("ovr_writes",    32'(wr_windows - snap),      32'd2);
        check("ovr4_writes",   32'(wr4_windows - snap4),    32'd2);

        // Capacity: 16 words fill after 8 frames, the 9th is ignored.
        iREC = 1'b0;
        frame('0, '0, 1'b0, 1'b0);
        iREC = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                push_wr(2*k,     16'(16'h3000 + k));
                push_wr(2*k + 1, 16'(16'h4000 + k));
            end
            snap = wr_windows;
            frame(16'(16'h3000 + k), 16'(16'h4000 + k), 1'b0, 1'b0);
            if (k == 6) begin
                check("cap7_full", 32'(full),    32'd0);
                check("cap7_len",  32'(rec_len), 32'd14);
            end
            if (k == 7) begin
                check("cap8_full", 32'(full),    32'd1);
                check("cap8_len",  32'(rec_len), 32'd0);
            end
            if (k == 8) begin
                check("cap9_no_write", 32'(wr_windows), 32'(snap));
                check("cap9_full",     32'(full),       32'd1);
            end
        end

        // Reset in the middle of a left access.
        iREC = 1'b0;
        frame('0, '0, 1'b0, 1'b0);
        iREC = 1'b1;
        push_wr(0, 16'hAAA1);
        push_wr(1, 16'hBBB1);
        frame(16'hAAA1, 16'hBBB1, 1'b0, 1'b0);
        check("pre_rst_len", 32'(rec_len), 32'd2);
        iIN_L = 16'hCCCC;
        iIN_R = 16'hDDDD;
        @(negedge iCLK) iLRCK = 1'b1;
        for (int i = 0; i < 20 && !sif.oSRAM_DQ_OE; i++) @(negedge iCLK);
        check("accl_reached", 32'(sif.oSRAM_DQ_OE), 32'd1);
        check("accl_addr",    32'(sif.oSRAM_ADDR),  32'd2);
        #2;
        iRST  = 1'b1;
        iLRCK = 1'b0;
        #1;
        check("arst_we_n",  32'(sif.oSRAM_WE_N),  32'd1);
        check("arst_oe_n",  32'(sif.oSRAM_OE_N),  32'd1);
        check("arst_dq_oe", 32'(sif.oSRAM_DQ_OE), 32'd0);
        check("arst_len",   32'(rec_len),         32'd0);
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        repeat (6) @(negedge iCLK);

        check("wr_queue_left",  32'(exp_wr.size()),  32'd0);
        check("out_queue_left", 32'(exp_out.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
